// File: rtl/group_sum_multi.sv
// group_sum_multi: sums L-digit IDs up to n_in whose decimal form is a repeated block
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 128
`endif

module group_sum_multi #(
    parameter int MODE     = 1,
    parameter int MAX_DIGS = 18,
    localparam int LW      = ($clog2(MAX_DIGS + 1) < 4) ? 4 : $clog2(MAX_DIGS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [`DATA_WIDTH-1:0]      n_in,
    input  logic [LW-1:0]               n_digs_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [`LONG_DATA_WIDTH-1:0] sum_out
);
    localparam int DW = `DATA_WIDTH;
    localparam int XW = `LONG_DATA_WIDTH;
    localparam logic [29:0] PRIMES = (30'd1 << 2) | (30'd1 << 3) | (30'd1 << 5) | (30'd1 << 7)
                                   | (30'd1 << 11) | (30'd1 << 13) | (30'd1 << 17) | (30'd1 << 19)
                                   | (30'd1 << 23) | (30'd1 << 29);

    typedef enum logic [2:0] {IDLE, SETUP, BASE, BOUND, MUL, ACC, DONE} state_t;

    state_t        state;
    logic [DW-1:0] n_q;
    logic [LW-1:0] l_q;
    logic [LW-1:0] b_q [3];
    logic [LW-1:0] r_q [3];
    logic [2:0]    neg_q;
    logic [1:0]    cnt_terms;
    logic [1:0]    t;
    logic [LW-1:0] cyc;
    logic [XW-1:0] base, pw, lb, ub, m, acc;

    int            lv, p1, p2, n_t;
    int            pr [3];
    logic [2:0]    neg_c;
    logic [LW-1:0] cur_b;
    logic [XW-1:0] step, lb_c, q, hi, ub_c, m_c, prod_bm, acc_nx;

    function automatic logic [XW-1:0] pow10(input logic [LW-1:0] e);
        logic [XW-1:0] p;
        p = XW'(1);
        for (int i = 0; i < 2 ** LW; i++)
            if (i < int'(e)) p = p * XW'(10);
        return p;
    endfunction

    // Derive the inclusion-exclusion term list (block-size divisors and signs) from L and MODE
    always_comb begin
        lv    = int'(l_q);
        p1    = 0;
        p2    = 0;
        n_t   = 0;
        pr[0] = 1;
        pr[1] = 1;
        pr[2] = 1;
        neg_c = 3'b000;
        for (int k = 2; k < 30; k++)
            if (PRIMES[k] && (lv % k == 0)) begin
                if (p1 == 0) p1 = k;
                else if (p2 == 0) p2 = k;
            end
        if (MODE == 0) begin
            if (lv % 2 == 0) begin
                n_t   = 1;
                pr[0] = 2;
            end
        end else if (p2 != 0) begin
            n_t   = 3;
            pr[0] = p1;
            pr[1] = p2;
            pr[2] = p1 * p2;
            neg_c = 3'b100;
        end else if (p1 != 0) begin
            n_t   = 1;
            pr[0] = p1;
        end
        if (lv < 2 || lv > MAX_DIGS) n_t = 0;
    end

    // Per-term datapath: powers, bounds, arithmetic-series sum and signed accumulation
    always_comb begin
        cur_b   = b_q[t];
        step    = pow10(cur_b);
        lb_c    = pow10(cur_b - LW'(1));
        q       = (base > XW'(n_q)) ? '0 : XW'(n_q / base[DW-1:0]);
        hi      = step - XW'(1);
        ub_c    = (q < hi) ? q : hi;
        m_c     = (ub < lb) ? '0 : ((lb + ub) * (ub - lb + XW'(1))) >> 1;
        prod_bm = base * m;
        acc_nx  = neg_q[t] ? acc - prod_bm : acc + prod_bm;
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum_out   <= '0;
            acc       <= '0;
            n_q       <= '0;
            l_q       <= '0;
            base      <= '0;
            pw        <= '0;
            lb        <= '0;
            ub        <= '0;
            m         <= '0;
            t         <= '0;
            cyc       <= '0;
            cnt_terms <= '0;
            neg_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                b_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    n_q      <= n_in;
                    l_q      <= n_digs_in;
                    acc      <= '0;
                    base     <= '0;
                    m        <= '0;
                    pw       <= XW'(1);
                    t        <= '0;
                    cyc      <= '0;
                    in_ready <= 1'b0;
                    state    <= SETUP;
                end
                SETUP: begin
                    for (int i = 0; i < 3; i++) begin
                        b_q[i] <= LW'(lv / pr[i]);
                        r_q[i] <= LW'(pr[i]);
                    end
                    neg_q     <= neg_c;
                    cnt_terms <= 2'(n_t);
                    state     <= (n_t == 0) ? ACC : BASE;
                end
                BASE: begin
                    base <= base + pw;
                    pw   <= pw * step;
                    if (cyc == r_q[t] - LW'(1)) begin
                        cyc   <= '0;
                        state <= BOUND;
                    end else begin
                        cyc <= cyc + LW'(1);
                    end
                end
                BOUND: begin
                    lb    <= lb_c;
                    ub    <= ub_c;
                    state <= MUL;
                end
                MUL: begin
                    m     <= m_c;
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc_nx;
                    if ({1'b0, t} + 3'd1 < {1'b0, cnt_terms}) begin
                        t     <= t + 2'd1;
                        base  <= '0;
                        pw    <= XW'(1);
                        state <= BASE;
                    end else begin
                        out_valid <= 1'b1;
                        sum_out   <= acc_nx;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
